// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller: forward-select
// encodings, register-index width and the shadow stage-slot record.
package pipe_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dest;
    logic             regwrite;
    logic             memtoreg;
  } stage_slot_t;

  // A slot produces a usable register result; $0 never counts as a producer.
  function automatic logic writes_reg(input stage_slot_t s);
    return s.valid & s.regwrite & (s.dest != '0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_fwd_select.sv
// Forward-select for one E-stage source operand: compares it against the M and
// W shadow slots, with the younger M result taking priority over W.
module fwd_select
  import pipe_pkg::*;
(
  input  logic             e_valid,
  input  logic [REG_W-1:0] e_src,
  input  stage_slot_t      m_slot,
  input  stage_slot_t      w_slot,
  output logic [1:0]       sel
);

  logic slot_unused;
  assign slot_unused = ^{m_slot.rs, m_slot.rt, m_slot.memtoreg,
                         w_slot.rs, w_slot.rt, w_slot.memtoreg};

  always_comb begin
    sel = FWD_RF;
    if (e_valid) begin
      if (writes_reg(m_slot) && (m_slot.dest == e_src)) begin
        sel = FWD_MEM;
      end else if (writes_reg(w_slot) && (w_slot.dest == e_src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the 5-stage core: shadows E/M/W, drives forwarding,
// load-use stalls, redirect flushes and the memory-wait freeze, plus counters.
module pipeline_hazard_controller
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REG_W = pipe_pkg::REG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_memtoreg,
  input  logic             ex_redirect,
  input  logic             mem_wait,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             freeze,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  stage_slot_t      e_q, m_q, w_q;
  stage_slot_t      id_slot;
  logic             load_use;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_comb begin
    id_slot          = '0;
    id_slot.valid    = id_valid;
    id_slot.rs       = id_rs;
    id_slot.rt       = id_rt;
    id_slot.dest     = id_dest;
    id_slot.regwrite = id_regwrite;
    id_slot.memtoreg = id_memtoreg;
  end

  assign load_use = e_q.valid & e_q.memtoreg & e_q.regwrite & (e_q.dest != '0) & id_valid &
                    ((e_q.dest == id_rs) | (id_uses_rt & (e_q.dest == id_rt)));

  // Priority: memory freeze, then redirect, then load-use.
  always_comb begin
    freeze  = mem_wait;
    stall_f = mem_wait | (~ex_redirect & load_use);
    stall_d = mem_wait | (~ex_redirect & load_use);
    flush_d = ~mem_wait & ex_redirect;
    flush_e = ~mem_wait & (ex_redirect | load_use);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!mem_wait) begin
      w_q <= m_q;
      m_q <= e_q;
      e_q <= (ex_redirect || load_use) ? '0 : id_slot;
      if (ex_redirect) begin
        if (!(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end else if (load_use) begin
        if (!(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

  fwd_select u_fwd_a (
    .e_valid (e_q.valid),
    .e_src   (e_q.rs),
    .m_slot  (m_q),
    .w_slot  (w_q),
    .sel     (fwd_a_e)
  );

  fwd_select u_fwd_b (
    .e_valid (e_q.valid),
    .e_src   (e_q.rt),
    .m_slot  (m_q),
    .w_slot  (w_q),
    .sel     (fwd_b_e)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: each driven cycle pushes its
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_pipeline_hazard_controller;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REG_W = 5;

  // ctl bits: {freeze, stall_f, stall_d, flush_d, flush_e}
  localparam logic [4:0] C0 = 5'b00000;
  localparam logic [4:0] LU = 5'b01101;
  localparam logic [4:0] RD = 5'b00011;
  localparam logic [4:0] FZ = 5'b11100;

  typedef struct {
    string      name;
    logic [4:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid, id_uses_rt, id_regwrite, id_memtoreg;
  logic [REG_W-1:0] id_rs, id_rt, id_dest;
  logic             ex_redirect, mem_wait;
  logic             stall_f, stall_d, flush_d, flush_e, freeze;
  logic [1:0]       fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0] stall_count, flush_count;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_dest     (id_dest),
    .id_regwrite (id_regwrite),
    .id_memtoreg (id_memtoreg),
    .ex_redirect (ex_redirect),
    .mem_wait    (mem_wait),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .freeze      (freeze),
    .fwd_a_e     (fwd_a_e),
    .fwd_b_e     (fwd_b_e),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  task automatic drive(input bit v, input int rs, input int rt, input bit urt,
                       input int dest, input bit rw, input bit mtr,
                       input bit redir, input bit mw);
    id_valid    = v;
    id_rs       = rs[REG_W-1:0];
    id_rt       = rt[REG_W-1:0];
    id_uses_rt  = urt;
    id_dest     = dest[REG_W-1:0];
    id_regwrite = rw;
    id_memtoreg = mtr;
    ex_redirect = redir;
    mem_wait    = mw;
  endtask

  task automatic step(input string nm, input bit v, input int rs, input int rt,
                      input bit urt, input int dest, input bit rw, input bit mtr,
                      input bit redir, input bit mw, input logic [4:0] ctl,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(v, rs, rt, urt, dest, rw, mtr, redir, mw);
    e.name = nm;
    e.ctl  = ctl;
    e.fa   = fa;
    e.fb   = fb;
    e.sc   = sc[CNT_W-1:0];
    e.fc   = fc[CNT_W-1:0];
    exp_q.push_back(e);
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1, 2, 2, 1, 3, 1, 0, 1, 0);
  endtask

  // Monitor: every cycle with a pending expectation is compared at negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [16:0] act, want;
      e    = exp_q.pop_front();
      act  = {freeze, stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, stall_count, flush_count};
      want = {e.ctl, e.fa, e.fb, e.sc, e.fc};
      tests++;
      if (act !== want) begin
        errors++;
        $display("FAIL %s: got ctl=%b fa=%b fb=%b sc=%0d fc=%0d, want ctl=%b fa=%b fb=%b sc=%0d fc=%0d",
                 e.name, act[16:12], act[11:10], act[9:8], act[7:4], act[3:0],
                 e.ctl, e.fa, e.fb, e.sc, e.fc);
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    reset_cycle();

    //    name            v rs rt urt dst rw mtr rdr mw  ctl fa     fb     sc fc
    step("reset_state",   0, 0, 0, 0,  0, 0, 0,  0, 0, C0, 2'b00, 2'b00, 0, 0);
    // load-use
    step("lw2_issue",     1, 1, 0, 0,  2, 1, 1,  0, 0, C0, 2'b00, 2'b00, 0, 0);
    step("lu_stall",      1, 2, 4, 1,  5, 1, 0,  0, 0, LU, 2'b00, 2'b00, 0, 0);
    step("lu_release",    1, 2, 4, 1,  5, 1, 0,  0, 0, C0, 2'b00, 2'b00, 1, 0);
    step("lu_fwd_wb",     0, 0, 0, 0,  0, 0, 0,  0, 0, C0, 2'b01, 2'b00, 1, 0);
    // M beats W
    step("p1_issue",      1, 6, 7, 1,  3, 1, 0,  0, 0, C0, 2'b00, 2'b00, 1, 0);
    step("p2_issue",      1, 8, 9, 1,  3, 1, 0,  0, 0, C0, 2'b00, 2'b00, 1, 0);
    step("cons_issue",    1, 3, 3, 1, 10, 1, 0,  0, 0, C0, 2'b00, 2'b00, 1, 0);
    step("m_over_w",      0, 0, 0, 0,  0, 0, 0,  0, 0, C0, 2'b10, 2'b10, 1, 0);
    // register $0
    step("z0_prod",       1, 1, 0, 0,  0, 1, 0,  0, 0, C0, 2'b00, 2'b00, 1, 0);
    step("z0_cons",       1, 0, 0, 1, 11, 1, 0,  0, 0, C0, 2'b00, 2'b00, 1, 0);
    step("z0_no_fwd_m",   1, 0, 0, 0,  0, 1, 1,  0, 0, C0, 2'b00, 2'b00, 1, 0);
    step("z0_no_stall",   1, 0, 0, 1, 12, 1, 0,  0, 0, C0, 2'b00, 2'b00, 1, 0);
    // redirect with a simultaneous load-use
    step("lw7_issue",     1, 1, 0, 0,  7, 1, 1,  0, 0, C0, 2'b00, 2'b00, 1, 0);
    step("redir_over_lu", 1, 7, 0, 0, 13, 1, 0,  1, 0, RD, 2'b00, 2'b00, 1, 0);
    step("post_redir",    0, 0, 0, 0,  0, 0, 0,  0, 0, C0, 2'b00, 2'b00, 1, 1);
    // memory wait during a load-use hazard; redirect ignored while frozen
    step("lw9_issue",     1, 1, 0, 0,  9, 1, 1,  0, 0, C0, 2'b00, 2'b00, 1, 1);
    step("mw_1",          1, 9, 0, 0, 14, 1, 0,  0, 1, FZ, 2'b00, 2'b00, 1, 1);
    step("mw_2_redir",    1, 9, 0, 0, 14, 1, 0,  1, 1, FZ, 2'b00, 2'b00, 1, 1);
    step("mw_3",          1, 9, 0, 0, 14, 1, 0,  0, 1, FZ, 2'b00, 2'b00, 1, 1);
    step("mw_lu_stall",   1, 9, 0, 0, 14, 1, 0,  0, 0, LU, 2'b00, 2'b00, 1, 1);
    step("mw_advance",    1, 9, 0, 0, 14, 1, 0,  0, 0, C0, 2'b00, 2'b00, 2, 1);
    step("mw_fwd_wb",     0, 0, 0, 0,  0, 0, 0,  0, 0, C0, 2'b01, 2'b00, 2, 1);

    // Back-to-back "lw $2,($2)" alternates advance/stall; 21 stalls from 2 saturates at 15.
    for (int i = 0; i < 42; i++) begin
      int         sc_exp;
      logic [4:0] c;
      logic [1:0] fa;
      sc_exp = 2 + i / 2;
      if (sc_exp > 15) sc_exp = 15;
      c  = (i % 2 == 1) ? LU : C0;
      fa = (i % 2 == 1 && i > 1) ? 2'b01 : 2'b00;
      step($sformatf("sat_%0d", i), 1, 2, 0, 0, 2, 1, 1, 0, 0, c, fa, 2'b00, sc_exp, 1);
    end
    step("sat_hold",      0, 0, 0, 0,  0, 0, 0,  0, 0, C0, 2'b00, 2'b00, 15, 1);

    // reset mid-operation with a load sitting in E
    step("pre_rst_lw2",   1, 5, 0, 0,  2, 1, 1,  0, 0, C0, 2'b00, 2'b00, 15, 1);
    reset_cycle();
    step("post_rst",      1, 2, 0, 0,  6, 1, 0,  0, 0, C0, 2'b00, 2'b00, 0, 0);
    step("post_rst_fwd",  0, 0, 0, 0,  0, 0, 0,  0, 0, C0, 2'b00, 2'b00, 0, 0);

    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && exp_q.size() == 0) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    if (!stim_done || exp_q.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL timeout: pending=%0d, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage pipelined core (F, D, E, M, W).
- Keeps its own shadow scoreboard of the E, M and W stages. From it, generates:
  - E-stage forwarding selects
  - load-use stalls
  - control-flow flushes
  - a global freeze while data memory is busy
- Sits beside the datapath. Consumes decode fields from the control unit and the register fields from the D-stage instruction.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of stall_count and flush_count (saturating).
- REG_W, 5, register-index width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  D stage holds a real instruction
- id_rs  input  REG_W  D-stage source register A
- id_rt  input  REG_W  D-stage source register B
- id_uses_rt  input  1  D-stage instruction reads rt (R-type, store, branch)
- id_dest  input  REG_W  D-stage destination (already muxed by RegDest/JAL)
- id_regwrite  input  1  D-stage RegWrite
- id_memtoreg  input  1  D-stage MemToReg (load)
- ex_redirect  input  1  E stage resolved a taken branch, JR or jump
- mem_wait  input  1  data memory not ready; freeze the whole pipeline
- stall_f  output  1  hold PC
- stall_d  output  1  hold IF/ID register
- flush_d  output  1  clear IF/ID register
- flush_e  output  1  clear ID/EX register (insert bubble)
- freeze  output  1  hold ID/EX, EX/MEM and MEM/WB registers
- fwd_a_e  output  2  E operand A select: 00 regfile, 01 W result, 10 M ALU result
- fwd_b_e  output  2  E operand B select, same encoding
- stall_count  output  CNT_W  load-use stall cycles
- flush_count  output  CNT_W  redirect flushes

Behaviour:
Scoreboard
- Three slots: E, M, W. Each slot holds valid, rs, rt, dest, regwrite, memtoreg.
- Reset clears every valid bit and both counters. All outputs read 0 in the cycle after reset.

Per cycle, with priority in this order:
1. mem_wait=1
   - freeze=1, stall_f=1, stall_d=1, flush_d=0, flush_e=0.
   - All slots and counters hold.
   - ex_redirect and load-use are ignored this cycle; they re-evaluate once the freeze lifts.
2. ex_redirect=1
   - flush_d=1, flush_e=1, stall_f=0, stall_d=0.
   - W<=M, M<=E, E<=bubble (valid=0).
   - flush_count increments.
   - Redirect overrides a simultaneous load-use hazard.
3. Load-use hazard
   - Condition: E.valid & E.memtoreg & E.regwrite & E.dest!=0 & id_valid & (E.dest==id_rs | (id_uses_rt & E.dest==id_rt)).
   - stall_f=1, stall_d=1, flush_e=1.
   - W<=M, M<=E, E<=bubble.
   - stall_count increments.
4. Otherwise
   - Normal advance: W<=M, M<=E, E<={id_valid, id_rs, id_rt, id_dest, id_regwrite, id_memtoreg}.
   - All control outputs 0.

Forwarding (combinational from slots)
- fwd_a_e=10 if M.valid & M.regwrite & M.dest!=0 & M.dest==E.rs.
- Else fwd_a_e=01 if W.valid & W.regwrite & W.dest!=0 & W.dest==E.rs.
- Else fwd_a_e=00.
- M has priority over W. fwd_b_e uses E.rt, same rules.
- When E.valid=0, both selects are 00.
- A load in M never forwards with 10: the load-use stall guarantees it reaches W first.

Register $0
- Never causes a stall or a forward.

Counters
- Saturate at all-ones; no wrap.

Timing
- Stall/flush outputs are combinational in the current cycle.
- Slot updates take effect at the next edge.
- Load-use costs exactly 1 bubble. A redirect costs 2 squashed instructions (D and E).

Reset mid-operation
- Overrides everything; the pipeline restarts empty.

Decomposition:
- Shared package `pipe_pkg`:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_W
  - a stage-slot struct (valid, rs, rt, dest, regwrite, memtoreg)
- One natural sub-module, `fwd_select`: combinational compare of one E source register against the M and W slots. Instantiate it twice, for A and B.

Test Plan:
- lw $2 in E (dest=2, memtoreg=1), D reads rs=2 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; next cycle fwd_a_e=01; stall_count=1.
- add $3 in M, add $3 in W, E reads rs=3, rt=3 -> fwd_a_e=10, fwd_b_e=10 (M wins over W).
- Producer with dest=0 and regwrite=1 in M, E reads rs=0 -> fwd_a_e=00. Load with dest=0 in E, D reads $0 -> no stall.
- ex_redirect=1 together with a load-use condition -> flush_d=flush_e=1, stall_f=0; flush_count=1, stall_count unchanged.
- mem_wait high for 3 cycles during a load-use hazard -> freeze=1 and slots unchanged for 3 cycles; then 1 load-use stall cycle, then normal advance.
- Force 2^CNT_W+5 load-use stalls (CNT_W=4 in the bench) -> stall_count holds at 15. Assert reset for one cycle -> all outputs 0 and slots invalid.
